inverse_bwt: RTL and testbench

Inverse Burrows-Wheeler transform engine: the decoder partner of the forward BWT block. It reads a transformed string (the last column `L`) from external byte memory and writes the original string to a separate output memory. It uses LF-mapping, with a per-symbol count table and a per-position rank array. Inputs are the string length and the primary index, the row whose rotation begins at original position 0.

---
 rtl/bwt_pkg.sv | 17 +
 rtl/ibwt_count_table.sv | 22 ++
 rtl/inverse_bwt.sv | 189 ++++++++++++++++++
 tb/tb_inverse_bwt.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bwt_pkg.sv
// Shared BWT definitions: alphabet size, default address/string sizing and decoder state encoding.
// Used by both the forward and the inverse transform engines.
package bwt_pkg;
  localparam int ALPHA       = 256;
  localparam int LEN_ADDR    = 10;
  localparam int MAX_LEN_STR = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_CNT,
    S_PFX,
    S_DRD,
    S_DWR,
    S_DONE
  } ibwt_state_t;
endpackage

// File: rtl/ibwt_count_table.sv
// Per-symbol count / prefix-sum table: combinational read, write on the clock edge.
// Read-before-write in the same cycle, so a read-modify-write completes in one cycle with no stall.
module ibwt_count_table
  import bwt_pkg::*;
#(
  parameter int len_addr = LEN_ADDR
) (
  input  logic                clk,
  input  logic [7:0]          rd_addr,
  output logic [len_addr-1:0] rd_dat,
  input  logic                wr_vld,
  input  logic [7:0]          wr_addr,
  input  logic [len_addr-1:0] wr_dat
);
  logic [len_addr-1:0] tbl_q [ALPHA];

  always_ff @(posedge clk) begin
    if (wr_vld) tbl_q[wr_addr] <= wr_dat;
  end

  assign rd_dat = tbl_q[rd_addr];
endmodule

// File: rtl/inverse_bwt.sv
// Inverse BWT by LF-mapping; flag rises 3n+514 edges after start (1 edge for empty/invalid input).
// CS low mid-run freezes all state and masks ren/wen; read data arriving during a pause is held.
module inverse_bwt
  import bwt_pkg::*;
#(
  parameter int len_addr    = LEN_ADDR,
  parameter int max_len_str = MAX_LEN_STR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                CS,
  input  logic [len_addr-1:0] len_str,
  input  logic [len_addr-1:0] prim_idx,
  input  logic [7:0]          din,
  output logic [len_addr-1:0] addr,
  output logic                ren,
  output logic [len_addr-1:0] addr1,
  output logic [7:0]          dout,
  output logic                wen,
  output logic                flag
);
  localparam logic [len_addr-1:0] ONE = len_addr'(1);

  ibwt_state_t         state_q, state_d;
  logic [len_addr-1:0] n_q, n_d, idx_q, idx_d, pos_q, pos_d, k_q, k_d;
  logic [len_addr-1:0] acc_q, acc_d, addr_q, addr_d;
  logic [7:0]          sym_q, sym_d, hold_q, hold_d;
  logic                ren_q, ren_d, wen_q, wen_d, flag_q, flag_d, rd_vld_q, rd_vld_d;

  logic [7:0]          dat, tbl_ra, tbl_wa;
  logic [len_addr-1:0] tbl_rd, tbl_wd, rank_wa, rank_rd;
  logic                tbl_we, rank_we;
  logic [len_addr-1:0] rank_q [max_len_str];

  // Read data is live only the cycle after an unmasked ren; otherwise use the captured copy.
  assign dat     = rd_vld_q ? din : hold_q;
  assign rank_rd = rank_q[idx_q];

  ibwt_count_table #(.len_addr(len_addr)) u_cnt (
    .clk     (clk),
    .rd_addr (tbl_ra),
    .rd_dat  (tbl_rd),
    .wr_vld  (tbl_we),
    .wr_addr (tbl_wa),
    .wr_dat  (tbl_wd)
  );

  always_ff @(posedge clk) begin
    if (rank_we) rank_q[rank_wa] <= tbl_rd;
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    k_d      = k_q;
    acc_d    = acc_q;
    addr_d   = addr_q;
    sym_d    = sym_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    flag_d   = flag_q;
    rd_vld_d = ren;
    hold_d   = dat;
    tbl_ra   = dat;
    tbl_we   = 1'b0;
    tbl_wa   = sym_q;
    tbl_wd   = '0;
    rank_we  = 1'b0;
    rank_wa  = pos_q - ONE;
    case (state_q)
      S_IDLE: if (CS) begin
        n_d   = len_str;
        idx_d = prim_idx;
        sym_d = '0;
        if (len_str == '0 || prim_idx >= len_str) begin
          state_d = S_DONE;
          flag_d  = 1'b1;
        end else begin
          state_d = S_CLR;
        end
      end
      S_CLR: if (CS) begin
        tbl_we = 1'b1;
        sym_d  = sym_q + 8'd1;
        if (sym_q == 8'hff) begin
          state_d = S_CNT;
          pos_d   = '0;
          ren_d   = 1'b1;
          addr_d  = '0;
        end
      end
      S_CNT: if (CS) begin
        // Cycle pos issues read pos and ranks the byte read in cycle pos-1.
        if (pos_q != '0) begin
          tbl_we  = 1'b1;
          tbl_wa  = dat;
          tbl_wd  = tbl_rd + ONE;
          rank_we = 1'b1;
        end
        pos_d  = pos_q + ONE;
        addr_d = pos_q + ONE;
        ren_d  = (pos_q + ONE) < n_q;
        if (pos_q == n_q) begin
          state_d = S_PFX;
          sym_d   = '0;
          acc_d   = '0;
          ren_d   = 1'b0;
        end
      end
      S_PFX: if (CS) begin
        tbl_ra = sym_q;
        tbl_we = 1'b1;
        tbl_wd = acc_q;
        acc_d  = acc_q + tbl_rd;
        sym_d  = sym_q + 8'd1;
        if (sym_q == 8'hff) begin
          state_d = S_DRD;
          k_d     = n_q - ONE;
          ren_d   = 1'b1;
          addr_d  = idx_q;
        end
      end
      S_DRD: if (CS) begin
        state_d = S_DWR;
        ren_d   = 1'b0;
        wen_d   = 1'b1;
      end
      S_DWR: if (CS) begin
        idx_d = tbl_rd + rank_rd;
        wen_d = 1'b0;
        if (k_q == '0) begin
          state_d = S_DONE;
          flag_d  = 1'b1;
        end else begin
          state_d = S_DRD;
          k_d     = k_q - ONE;
          ren_d   = 1'b1;
          addr_d  = tbl_rd + rank_rd;
        end
      end
      S_DONE: if (!CS) begin
        state_d = S_IDLE;
        flag_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      pos_q    <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      addr_q   <= '0;
      sym_q    <= '0;
      hold_q   <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      flag_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      sym_q    <= sym_d;
      hold_q   <= hold_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      flag_q   <= flag_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign addr  = addr_q;
  assign ren   = ren_q & CS;
  assign wen   = wen_q & CS;
  assign addr1 = k_q;
  assign dout  = dat;
  assign flag  = flag_q;
endmodule

// File: tb/tb_inverse_bwt.sv
// Directed and random runs of inverse_bwt against behavioural L-memory/output-memory models.
// Random cases derive L and the primary index by sorting rotations of a random source string.
module tb_inverse_bwt;
  localparam int LA = 10;

  logic          clk = 1'b0;
  logic          reset, CS;
  logic [LA-1:0] len_str, prim_idx, addr, addr1;
  logic [7:0]    din, dout;
  logic          ren, wen, flag;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int overlap = 0;
  logic [7:0] lmem  [1024];
  logic [7:0] omem  [1024];
  logic [7:0] exp_s [1024];
  int wr_addr_q[$];

  inverse_bwt #(.len_addr(LA), .max_len_str(1024)) dut (
    .clk      (clk),
    .reset    (reset),
    .CS       (CS),
    .len_str  (len_str),
    .prim_idx (prim_idx),
    .din      (din),
    .addr     (addr),
    .ren      (ren),
    .addr1    (addr1),
    .dout     (dout),
    .wen      (wen),
    .flag     (flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous L memory; garbage on idle cycles so stale data is never trusted.
  always @(posedge clk) begin
    if (ren) din <= lmem[addr];
    else     din <= 8'($urandom);
  end

  always @(negedge clk) begin
    if (wen) begin
      wr_addr_q.push_back(int'(addr1));
      omem[addr1] = dout;
    end
    if (ren && wen) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ren"},   32'(ren),   0);
    chk({tag, "_wen"},   32'(wen),   0);
    chk({tag, "_flag"},  32'(flag),  0);
    chk({tag, "_addr"},  32'(addr),  0);
    chk({tag, "_addr1"}, 32'(addr1), 0);
    chk({tag, "_dout"},  32'(dout),  0);
  endtask

  task automatic set_str(input string l, input string s);
    for (int i = 0; i < l.len(); i++) begin
      lmem[i]  = l[i];
      exp_s[i] = s[i];
    end
  endtask

  function automatic int rot_cmp(input int a, input int b, input int n);
    for (int t = 0; t < n; t++) begin
      if (exp_s[(a + t) % n] < exp_s[(b + t) % n]) return -1;
      if (exp_s[(a + t) % n] > exp_s[(b + t) % n]) return 1;
    end
    return 0;
  endfunction

  // Forward BWT of exp_s[0..n-1]; returns 1 if two rotations are identical.
  function automatic bit build_bwt(input int n, output int pidx);
    int rows[$];
    int tmp;
    bit tie = 1'b0;
    pidx = 0;
    for (int i = 0; i < n; i++) rows.push_back(i);
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0 && rot_cmp(rows[j-1], rows[j], n) > 0; j--) begin
        tmp = rows[j]; rows[j] = rows[j-1]; rows[j-1] = tmp;
      end
    end
    for (int r = 0; r < n; r++) begin
      lmem[r] = exp_s[(rows[r] + n - 1) % n];
      if (rows[r] == 0) pidx = r;
      if (r > 0 && rot_cmp(rows[r-1], rows[r], n) == 0) tie = 1'b1;
    end
    return tie;
  endfunction

  task automatic run_ibwt(input int n, input int pidx, input int exp_writes,
                          input int pause_at, input int exp_edge);
    int  t0;
    bit  got = 1'b0;
    wr_addr_q.delete();
    overlap = 0;
    for (int i = 0; i < 1024; i++) omem[i] = 8'h00;
    len_str  = LA'(n);
    prim_idx = LA'(pidx);
    @(posedge clk);
    #1 CS = 1'b1;
    t0 = cyc;
    for (int e = 0; e < 20000 && !got; e++) begin
      @(negedge clk);
      if (flag) got = 1'b1;
      else if (pause_at >= 0 && ren && wr_addr_q.size() == pause_at) begin
        pause_at = -1;
        @(posedge clk);
        #1 CS = 1'b0;
        for (int p = 0; p < 10; p++) begin
          @(negedge clk);
          chk("pause_ren", 32'(ren), 0);
          chk("pause_wen", 32'(wen), 0);
          @(posedge clk);
        end
        #1 CS = 1'b1;
      end
    end
    chk("flag_seen", 32'(got), 1);
    chk("flag_edge", cyc - t0, exp_edge);
    chk("n_writes", wr_addr_q.size(), exp_writes);
    for (int i = 0; i < wr_addr_q.size(); i++) chk("wr_addr_order", wr_addr_q[i], n - 1 - i);
    if (exp_writes > 0)
      for (int i = 0; i < n; i++) chk("out_byte", 32'(omem[i]), 32'(exp_s[i]));
    chk("ren_wen_overlap", overlap, 0);
    repeat (3) @(negedge clk);
    chk("flag_hold", 32'(flag), 1);
    @(posedge clk);
    #1 CS = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("flag_clear", 32'(flag), 0);
  endtask

  initial begin
    int n, pidx, tries;
    bit tie;
    reset = 1'b1; CS = 1'b0; len_str = '0; prim_idx = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst");
    reset = 1'b0;

    set_str("nnbaaa", "banana");
    run_ibwt(6, 3, 6, -1, 532);

    set_str("x", "x");
    run_ibwt(1, 0, 1, -1, 517);

    set_str("aaaaaaaa", "aaaaaaaa");
    run_ibwt(8, 0, 8, -1, 538);

    run_ibwt(6, 6, 0, -1, 1);
    run_ibwt(0, 0, 0, -1, 1);
    run_ibwt(5, 1023, 0, -1, 1);

    set_str("nnbaaa", "banana");
    run_ibwt(6, 3, 6, 2, 542);

    // Abort a run in the middle of the histogram pass.
    len_str = 6; prim_idx = 3;
    @(posedge clk);
    #1 CS = 1'b1;
    repeat (261) @(posedge clk);
    @(negedge clk);
    chk("mid_cnt_ren", 32'(ren), 1);
    reset = 1'b1; CS = 1'b0;
    #1 chk_reset_outputs("abort");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wr_addr_q.delete();
    repeat (20) @(negedge clk);
    chk("abort_no_wen", wr_addr_q.size(), 0);
    chk("abort_flag", 32'(flag), 0);
    run_ibwt(6, 3, 6, -1, 532);

    for (int r = 0; r < 4; r++) begin
      tries = 0;
      do begin
        n = (r == 3) ? 60 : $urandom_range(2, 40);
        for (int i = 0; i < n; i++)
          exp_s[i] = (r == 3) ? 8'($urandom) : 8'(97 + $urandom_range(0, 3));
        tie = build_bwt(n, pidx);
        tries++;
      end while (tie && tries < 50);
      run_ibwt(n, pidx, n, -1, 3 * n + 514);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
